// File: rtl/game_pkg.sv
// Shared game-pipeline definitions: datapath command encodings, colours and
// default geometry/timing for the wall and player blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ALU_UPDATE_WALL  = 2'd0,
    ALU_DEL_WALL     = 2'd1,
    ALU_DRAW_WALL    = 2'd2,
    ALU_UPDATE_SCORE = 2'd3
  } alu_sel_e;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WALL   = 3'b010;
  localparam logic [2:0] COL_PLAYER = 3'b110;
  localparam logic [2:0] COL_TEXT   = 3'b111;

  localparam int WALL_PIXELS_DEF = 1200;
  localparam int FRAME_DIV_DEF   = 833333;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame divider: counts DIV-1 down to 0, ticks for one cycle at 0
// and reloads. Shared by the wall and player controllers.
module frame_timer #(
  parameter int DIV = 833333
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_cnt <= RELOAD;
    else if (r_cnt == '0)   r_cnt <= RELOAD;
    else                    r_cnt <= r_cnt - CW'(1);
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/wall_control.sv
// Wall control FSM: paces the wall per frame tick and sequences erase, move,
// redraw, collision check and score update on the wall datapath.
module wall_control
  import game_pkg::*;
#(
  parameter int FRAME_DIV   = FRAME_DIV_DEF,
  parameter int WALL_PIXELS = WALL_PIXELS_DEF,
  parameter int IDX_W       = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             collision,
  input  logic             wall_wrap,
  output logic [1:0]       alu_select,
  output logic             op_valid,
  output logic             dp_clear,
  output logic             plot,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             busy,
  output logic             game_over
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT      = 4'd1;
  localparam logic [3:0] S_INIT_DRAW = 4'd2;
  localparam logic [3:0] S_WAIT      = 4'd3;
  localparam logic [3:0] S_DEL       = 4'd4;
  localparam logic [3:0] S_MOVE      = 4'd5;
  localparam logic [3:0] S_DRAW      = 4'd6;
  localparam logic [3:0] S_CHECK     = 4'd7;
  localparam logic [3:0] S_SCORE     = 4'd8;
  localparam logic [3:0] S_OVER      = 4'd9;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WALL_PIXELS - 1);

  logic [3:0]       r_state, w_nstate;
  logic [IDX_W-1:0] r_idx, w_nidx;
  logic             r_go_s, r_go_q, r_pend;
  logic             w_tick, w_go_rise, w_last;
  logic [1:0]       w_alu;
  logic             w_op, w_clr, w_plot, w_busy, w_over;

  frame_timer #(.DIV(FRAME_DIV)) u_timer (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .o_tick  (w_tick)
  );

  assign w_go_rise = r_go_s & ~r_go_q;
  assign w_last    = (r_idx == LAST_IDX);

  always_comb begin
    w_nstate = r_state;
    w_nidx   = '0;
    case (r_state)
      S_IDLE:      if (w_go_rise) w_nstate = S_INIT;
      S_INIT:      w_nstate = S_INIT_DRAW;
      S_INIT_DRAW: if (w_last) w_nstate = S_WAIT;  else w_nidx = r_idx + IDX_W'(1);
      S_WAIT:      if (w_tick || r_pend) w_nstate = S_DEL;
      S_DEL:       if (w_last) w_nstate = S_MOVE;  else w_nidx = r_idx + IDX_W'(1);
      S_MOVE:      w_nstate = S_DRAW;
      S_DRAW:      if (w_last) w_nstate = S_CHECK; else w_nidx = r_idx + IDX_W'(1);
      S_CHECK: begin
        if (collision)      w_nstate = S_OVER;
        else if (wall_wrap) w_nstate = S_SCORE;
        else                w_nstate = S_WAIT;
      end
      S_SCORE:     w_nstate = S_WAIT;
      S_OVER:      if (w_go_rise) w_nstate = S_INIT;
      default:     w_nstate = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_alu  = ALU_UPDATE_WALL;
    w_op   = 1'b0;
    w_clr  = 1'b0;
    w_plot = 1'b0;
    case (w_nstate)
      S_INIT:              w_clr = 1'b1;
      S_INIT_DRAW, S_DRAW: begin w_alu = ALU_DRAW_WALL; w_plot = 1'b1; end
      S_DEL:               begin w_alu = ALU_DEL_WALL;  w_plot = 1'b1; end
      S_MOVE:              w_op = 1'b1;
      S_SCORE:             begin w_alu = ALU_UPDATE_SCORE; w_op = 1'b1; end
      default:             ;
    endcase
    w_busy = !(w_nstate == S_IDLE || w_nstate == S_WAIT || w_nstate == S_OVER);
    w_over = (w_nstate == S_OVER);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_go_s     <= 1'b0;
      r_go_q     <= 1'b0;
      r_pend     <= 1'b0;
      alu_select <= '0;
      op_valid   <= 1'b0;
      dp_clear   <= 1'b0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_idx      <= w_nidx;
      r_go_s     <= go;
      r_go_q     <= r_go_s;
      alu_select <= w_alu;
      op_valid   <= w_op;
      dp_clear   <= w_clr;
      plot       <= w_plot;
      busy       <= w_busy;
      game_over  <= w_over;
      // One-deep pending tick; discarded while idle or game over.
      if (r_state == S_IDLE || r_state == S_OVER || r_state == S_WAIT) r_pend <= 1'b0;
      else if (w_tick)                                                  r_pend <= 1'b1;
    end
  end

  assign pixel_idx = r_idx;

endmodule
